// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared state encodings and owner codes for the SRAM arbiter
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic OWNER_AVR  = 1'b0;
  localparam logic OWNER_SNES = 1'b1;

endpackage

// File: rtl/sram_cycle_timer.sv
// rtl/sram_cycle_timer.sv - loadable 4-bit down-counter timing the SRAM strobe width
module sram_cycle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [3:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM between the AVR port and the SNES read port
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int STARVE_MAX  = 4
) (
  input  logic              avr_clk,
  input  logic              avr_reset_n,
  input  logic              avr_req,
  input  logic              avr_we,
  input  logic [ADDR_W-1:0] avr_addr,
  input  logic [DATA_W-1:0] avr_wdata,
  output logic [DATA_W-1:0] avr_rdata,
  output logic              avr_ack,
  input  logic              snes_req,
  input  logic [ADDR_W-1:0] snes_addr,
  output logic [DATA_W-1:0] snes_rdata,
  output logic              snes_ack,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_data_i,
  output logic [DATA_W-1:0] sram_data_o,
  output logic              sram_data_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              owner
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);

  state_t          state, state_nx;
  logic            acc_we, cur_we;
  logic            grant_avr, grant_snes;
  logic            timer_done, last_access;
  logic [SC_W-1:0] starve;

  sram_cycle_timer u_timer (
    .clk      (avr_clk),
    .rst_n    (avr_reset_n),
    .load     (state == ST_SETUP),
    .load_val (4'(WAIT_CYCLES - 1)),
    .en       (state == ST_ACCESS),
    .done     (timer_done)
  );

  // SNES wins ties until the AVR has been passed over STARVE_MAX times
  always_comb begin
    grant_avr  = 1'b0;
    grant_snes = 1'b0;
    if (state == ST_IDLE) begin
      if (avr_req && (!snes_req || (starve == SC_W'(STARVE_MAX)))) begin
        grant_avr = 1'b1;
      end else if (snes_req) begin
        grant_snes = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (grant_avr || grant_snes) state_nx = ST_SETUP;
      ST_SETUP:  state_nx = ST_ACCESS;
      ST_ACCESS: if (timer_done) state_nx = ST_HOLD;
      ST_HOLD:   state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  assign cur_we      = grant_avr ? avr_we : (grant_snes ? 1'b0 : acc_we);
  assign last_access = (state == ST_ACCESS) && timer_done;

  // strobes are computed from the next state so every pin comes straight off a flop
  always_ff @(posedge avr_clk or negedge avr_reset_n) begin
    if (!avr_reset_n) begin
      state        <= ST_IDLE;
      acc_we       <= 1'b0;
      starve       <= '0;
      owner        <= OWNER_AVR;
      sram_addr    <= '0;
      sram_data_o  <= '0;
      sram_data_oe <= 1'b0;
      sram_ce_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_we_n    <= 1'b1;
      avr_ack      <= 1'b0;
      snes_ack     <= 1'b0;
      avr_rdata    <= '0;
      snes_rdata   <= '0;
    end else begin
      state        <= state_nx;
      acc_we       <= cur_we;
      sram_ce_n    <= !((state_nx == ST_SETUP) || (state_nx == ST_ACCESS));
      sram_oe_n    <= !((state_nx == ST_ACCESS) && !cur_we);
      sram_we_n    <= !((state_nx == ST_ACCESS) && cur_we);
      sram_data_oe <= cur_we && (state_nx != ST_IDLE);
      avr_ack      <= last_access && (owner == OWNER_AVR);
      snes_ack     <= last_access && (owner == OWNER_SNES);
      if (grant_avr || grant_snes) begin
        owner     <= grant_snes ? OWNER_SNES : OWNER_AVR;
        sram_addr <= grant_snes ? snes_addr : avr_addr;
      end
      if (grant_avr && avr_we) sram_data_o <= avr_wdata;
      if (last_access && !acc_we) begin
        if (owner == OWNER_SNES) snes_rdata <= sram_data_i;
        else                     avr_rdata  <= sram_data_i;
      end
      if (grant_avr || ((state == ST_IDLE) && !avr_req)) begin
        starve <= '0;
      end else if (grant_snes && (starve != SC_W'(STARVE_MAX))) begin
        starve <= starve + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter against a transaction-level model
module tb_sram_arbiter;

  localparam int WAIT = 2;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        avr_req = 1'b0, avr_we = 1'b0, snes_req = 1'b0;
  logic [20:0] avr_addr = '0, snes_addr = '0;
  logic [7:0]  avr_wdata = '0, sram_data_i = '0;
  logic [7:0]  avr_rdata, snes_rdata, sram_data_o;
  logic [20:0] sram_addr;
  logic        avr_ack, snes_ack, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n, owner;

  int checks = 0;
  int failures = 0;

  sram_arbiter #(.ADDR_W(21), .DATA_W(8), .WAIT_CYCLES(WAIT), .STARVE_MAX(SMAX)) dut (
    .avr_clk(clk), .avr_reset_n(rst_n),
    .avr_req(avr_req), .avr_we(avr_we), .avr_addr(avr_addr), .avr_wdata(avr_wdata),
    .avr_rdata(avr_rdata), .avr_ack(avr_ack),
    .snes_req(snes_req), .snes_addr(snes_addr), .snes_rdata(snes_rdata), .snes_ack(snes_ack),
    .sram_addr(sram_addr), .sram_data_i(sram_data_i), .sram_data_o(sram_data_o),
    .sram_data_oe(sram_data_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .owner(owner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access occupies phases 0..WAIT+1 after its grant edge, then one idle cycle
  bit        m_busy = 1'b0;
  int        m_k = 0;
  bit        m_we = 1'b0, m_owner = 1'b0;
  bit [20:0] m_addr = '0;
  bit [7:0]  m_dout = '0, m_avr_rd = '0, m_snes_rd = '0;
  int        m_starve = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_k <= 0; m_we <= 1'b0; m_owner <= 1'b0; m_addr <= '0;
      m_dout <= '0; m_avr_rd <= '0; m_snes_rd <= '0; m_starve <= 0;
    end else if (m_busy) begin
      m_k <= m_k + 1;
      if (m_k == WAIT && !m_we) begin
        if (m_owner) m_snes_rd <= sram_data_i;
        else         m_avr_rd  <= sram_data_i;
      end
      if (m_k == WAIT + 1) m_busy <= 1'b0;
    end else begin
      if (avr_req && (!snes_req || m_starve == SMAX)) begin
        m_busy <= 1'b1; m_k <= 0; m_owner <= 1'b0; m_we <= avr_we; m_addr <= avr_addr;
        if (avr_we) m_dout <= avr_wdata;
        m_starve <= 0;
      end else if (snes_req) begin
        m_busy <= 1'b1; m_k <= 0; m_owner <= 1'b1; m_we <= 1'b0; m_addr <= snes_addr;
        if (!avr_req) m_starve <= 0;
        else if (m_starve < SMAX) m_starve <= m_starve + 1;
      end else begin
        m_starve <= 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] e_str;
    logic [1:0] e_ack;
    e_ack = 2'b00;
    if (!m_busy)               e_str = 4'b1110;
    else if (m_k == 0)         e_str = {3'b011, m_we};
    else if (m_k <= WAIT)      e_str = {1'b0, m_we, !m_we, m_we};
    else begin
      e_str = {3'b111, m_we};
      e_ack = m_owner ? 2'b01 : 2'b10;
    end
    chk("strobes_ce_oe_we_doe", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}), 32'(e_str));
    chk("acks_avr_snes", 32'({avr_ack, snes_ack}), 32'(e_ack));
    chk("sram_addr", 32'(sram_addr), 32'(m_addr));
    chk("sram_data_o", 32'(sram_data_o), 32'(m_dout));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("avr_rdata", 32'(avr_rdata), 32'(m_avr_rd));
    chk("snes_rdata", 32'(snes_rdata), 32'(m_snes_rd));
    chk("oe_we_overlap", 32'(!sram_oe_n && !sram_we_n), 32'd0);
    chk("doe_with_oe", 32'(sram_data_oe && !sram_oe_n), 32'd0);
  end

  task automatic do_access(input bit snes, input bit we, input logic [20:0] addr,
                           input logic [7:0] wd, input logic [7:0] din,
                           output int lat, output int ce_c, output int oe_c,
                           output int we_c, output int doe_c);
    lat = 0; ce_c = 0; oe_c = 0; we_c = 0; doe_c = 0;
    @(negedge clk);
    sram_data_i = din;
    if (snes) begin
      snes_addr = addr; snes_req = 1'b1;
    end else begin
      avr_addr = addr; avr_we = we; avr_wdata = wd; avr_req = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      ce_c  += int'(!sram_ce_n);
      oe_c  += int'(!sram_oe_n);
      we_c  += int'(!sram_we_n);
      doe_c += int'(sram_data_oe);
      if ((snes && snes_ack) || (!snes && avr_ack)) break;
    end
    avr_req = 1'b0;
    snes_req = 1'b0;
  endtask

  initial begin
    int lat, ce_c, oe_c, we_c, doe_c, n, acks;
    logic [9:0] order, exp_order;

    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}), 32'hE);
    chk("reset_acks_owner", 32'({avr_ack, snes_ack, owner}), 32'd0);
    chk("reset_data", 32'({sram_addr, sram_data_o}), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // 1: AVR read
    do_access(1'b0, 1'b0, 21'h1abcd, 8'h00, 8'haa, lat, ce_c, oe_c, we_c, doe_c);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_ce_cycles", 32'(ce_c), 32'd3);
    chk("t1_oe_cycles", 32'(oe_c), 32'd2);
    chk("t1_we_cycles", 32'(we_c), 32'd0);
    chk("t1_rdata", 32'(avr_rdata), 32'haa);
    chk("t1_addr", 32'(sram_addr), 32'h1abcd);

    // 2: AVR write
    do_access(1'b0, 1'b1, 21'h00010, 8'hee, 8'h00, lat, ce_c, oe_c, we_c, doe_c);
    chk("t2_we_cycles", 32'(we_c), 32'd2);
    chk("t2_oe_cycles", 32'(oe_c), 32'd0);
    chk("t2_doe_cycles", 32'(doe_c), 32'd4);
    chk("t2_data_o", 32'(sram_data_o), 32'hee);
    chk("t2_rdata_kept", 32'(avr_rdata), 32'haa);
    @(negedge clk);
    chk("t2_doe_dropped", 32'(sram_data_oe), 32'd0);

    // 3: both requesting continuously
    @(negedge clk);
    avr_we = 1'b0; avr_addr = 21'h00123; snes_addr = 21'h00456;
    avr_req = 1'b1; snes_req = 1'b1;
    n = 0; order = '0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      if (avr_ack) begin order[n] = 1'b0; n++; end
      else if (snes_ack) begin order[n] = 1'b1; n++; end
    end
    avr_req = 1'b0; snes_req = 1'b0;
    exp_order = 10'b0111101111;
    chk("t3_grant_count", 32'(n), 32'd10);
    chk("t3_grant_order", 32'(order), 32'(exp_order));

    // 4: SNES read at top address
    do_access(1'b1, 1'b0, 21'h1fffff, 8'h00, 8'hbb, lat, ce_c, oe_c, we_c, doe_c);
    chk("t4_latency", 32'(lat), 32'd4);
    chk("t4_rdata", 32'(snes_rdata), 32'hbb);
    chk("t4_we_cycles", 32'(we_c), 32'd0);
    chk("t4_doe_cycles", 32'(doe_c), 32'd0);
    chk("t4_addr", 32'(sram_addr), 32'h1fffff);

    // 5: reset in the middle of a write
    @(negedge clk);
    avr_addr = 21'h00200; avr_we = 1'b1; avr_wdata = 8'h5a; avr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_we_low", 32'(sram_we_n), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_strobes", 32'({sram_ce_n, sram_we_n, sram_data_oe}), 32'h6);
    avr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      acks += int'(avr_ack | snes_ack);
    end
    chk("t5_no_ack", 32'(acks), 32'd0);
    chk("t5_idle", 32'({sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}), 32'hE);

    // 6: address change after grant is ignored
    @(negedge clk);
    sram_data_i = 8'h3c; avr_addr = 21'h0abcd; avr_we = 1'b0; avr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    avr_addr = 21'h15555;
    @(negedge clk);
    chk("t6_addr_held", 32'(sram_addr), 32'h0abcd);
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      if (avr_ack) begin acks = 1; break; end
      @(negedge clk);
    end
    avr_req = 1'b0;
    chk("t6_acked", 32'(acks), 32'd1);
    chk("t6_rdata", 32'(avr_rdata), 32'h3c);
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
